// File: rtl/mci_wdt_multi.sv
// Multi-channel watchdog: NUM_TIMERS channels with CW-bit periods, running
// independently or as a cascade where each expiry starts the next channel.
module mci_wdt_multi #(
  parameter int unsigned NUM_TIMERS    = 3,
  parameter int unsigned PERIOD_DWORDS = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_b,
  input  logic                                      cascade_en,
  input  logic [NUM_TIMERS-1:0]                     timer_en,
  input  logic [NUM_TIMERS-1:0]                     timer_restart,
  input  logic [NUM_TIMERS-1:0][PERIOD_DWORDS-1:0][31:0] timer_period,
  input  logic [NUM_TIMERS-1:0]                     timeout_serviced,
  output logic [NUM_TIMERS-1:0]                     active,
  output logic [NUM_TIMERS-1:0]                     timeout_p,
  output logic [NUM_TIMERS-1:0]                     timeout,
  output logic                                      fatal_timeout
);

  localparam int unsigned CW = 32 * PERIOD_DWORDS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  logic                  cascade_q;
  logic                  mode_chg;
  logic                  svc_up;
  logic [NUM_TIMERS-1:0] force_idle;
  logic [NUM_TIMERS-1:0] start;
  logic [NUM_TIMERS-1:0] tp_next;

  assign mode_chg = cascade_en ^ cascade_q;

  // In cascade mode a service or a channel-0 disable tears down everything downstream.
  always_comb begin
    force_idle = '0;
    svc_up     = 1'b0;
    for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
      if (cascade_en) begin
        force_idle[i] = mode_chg | ~timer_en[0] | svc_up;
        svc_up        = svc_up | timeout_serviced[i];
      end else begin
        force_idle[i] = mode_chg | ~timer_en[i];
      end
    end
    start = cascade_en ? {timeout_p[NUM_TIMERS-2:0], timer_en[0]} : timer_en;
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   period;
    logic            at_limit;
    logic            tp_q, tp_d;
    logic            to_q, to_d;
    logic            act_q;

    assign period   = timer_period[g];
    assign at_limit = ({1'b0, cnt_q} + {{CW{1'b0}}, 1'b1}) >= {1'b0, period};

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        tp_q    <= 1'b0;
        to_q    <= 1'b0;
        act_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tp_q    <= tp_d;
        to_q    <= to_d;
        act_q   <= (state_d == COUNT);
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (force_idle[g]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start[g] && (period != '0)) begin
              state_d = COUNT;
              cnt_d   = '0;
            end
          end
          COUNT: begin
            if (timer_restart[g])  cnt_d   = '0;
            else if (at_limit)     state_d = EXPIRED;
            else                   cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
          EXPIRED: begin
            if (timeout_serviced[g]) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Expiry beats a coincident service, restart beats a coincident expiry.
    always_comb begin
      tp_d = ~force_idle[g] & (state_q == COUNT) & ~timer_restart[g] & at_limit;
      to_d = tp_d | (to_q & ~timeout_serviced[g]);
    end

    assign tp_next[g]   = tp_d;
    assign timeout_p[g] = tp_q;
    assign timeout[g]   = to_q;
    assign active[g]    = act_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cascade_q     <= 1'b0;
      fatal_timeout <= 1'b0;
    end else begin
      cascade_q     <= cascade_en;
      fatal_timeout <= fatal_timeout | tp_next[NUM_TIMERS-1];
    end
  end

endmodule

// File: tb/tb_mci_wdt_multi.sv
// Directed and randomized checks of mci_wdt_multi against a deadline-based
// reference model (expiry tracked as an absolute edge number, not a counter).
module tb_mci_wdt_multi;
  localparam int N  = 3;
  localparam int PD = 2;

  logic                       clk = 1'b0;
  logic                       rst_b;
  logic                       cascade_en;
  logic [N-1:0]               en, rst_p, svc;
  logic [N-1:0][PD-1:0][31:0] period;
  logic [N-1:0]               active, timeout_p, timeout;
  logic                       fatal_timeout;

  mci_wdt_multi #(.NUM_TIMERS(N), .PERIOD_DWORDS(PD)) dut (
    .clk(clk), .rst_b(rst_b), .cascade_en(cascade_en),
    .timer_en(en), .timer_restart(rst_p), .timer_period(period),
    .timeout_serviced(svc), .active(active), .timeout_p(timeout_p),
    .timeout(timeout), .fatal_timeout(fatal_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: state 0=idle 1=count 2=expired; deadline = edge number of expiry
  int                m_st [N];
  longint unsigned   m_dl [N];
  bit                m_tp [N];
  bit                m_to [N];
  bit                m_fatal;
  bit                m_casc;
  longint unsigned   n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_dl[i] = 0; m_tp[i] = 0; m_to[i] = 0;
    end
    m_fatal = 0; m_casc = 0; n = 0;
  endtask

  task automatic model_edge();
    int  ns [N];
    bit  nt [N];
    bit  svc_before = 0;
    bit  toggle;
    n++;
    toggle = (cascade_en != m_casc);
    for (int i = 0; i < N; i++) begin
      longint unsigned p = period[i];
      bit start, kill;
      if (cascade_en) begin
        start = (i == 0) ? en[0] : m_tp[i-1];
        kill  = toggle || !en[0] || svc_before;
      end else begin
        start = en[i];
        kill  = toggle || !en[i];
      end
      ns[i] = m_st[i];
      nt[i] = 0;
      if (kill) ns[i] = 0;
      else if (m_st[i] == 0) begin
        if (start && p != 0) begin ns[i] = 1; m_dl[i] = n + p; end
      end else if (m_st[i] == 1) begin
        if (rst_p[i]) m_dl[i] = n + p;
        else if (n >= m_dl[i]) begin ns[i] = 2; nt[i] = 1; end
      end else if (svc[i]) ns[i] = 0;
      svc_before = svc_before | svc[i];
    end
    for (int i = 0; i < N; i++) begin
      m_st[i] = ns[i];
      m_tp[i] = nt[i];
      m_to[i] = nt[i] ? 1'b1 : (svc[i] ? 1'b0 : m_to[i]);
    end
    m_fatal = m_fatal | nt[N-1];
    m_casc  = cascade_en;
  endtask

  task automatic tick();
    logic [N-1:0] ea, et, eo;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      ea[i] = (m_st[i] == 1); et[i] = m_tp[i]; eo[i] = m_to[i];
    end
    chk("active", active, ea);
    chk("timeout_p", timeout_p, et);
    chk("timeout", timeout, eo);
    chk("fatal", fatal_timeout, m_fatal);
  endtask

  task automatic do_reset();
    rst_b = 1'b0; cascade_en = 1'b0; en = '0; rst_p = '0; svc = '0; period = '0;
    #3;
    chk("rst_active", active, 0);
    chk("rst_timeout_p", timeout_p, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_fatal", fatal_timeout, 0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    // independent expiry, enable captured at edge 5
    do_reset();
    period[0] = 10;
    repeat (4) tick();
    en[0] = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("ind_tp0", timeout_p[0], (k == 10) ? 1 : 0);
    end
    chk("ind_to0", timeout[0], 1);
    chk("ind_fatal", fatal_timeout, 0);
    chk("ind_act0", active[0], 0);

    // periodic restart keeps the watchdog quiet; restart at count 9 wins
    do_reset();
    period[0] = 10;
    en[0] = 1'b1;
    tick();
    for (int k = 1; k <= 1000; k++) begin
      rst_p[0] = (k % 8 == 0);
      tick();
      chk("rstrt_tp0", timeout_p[0], 0);
    end
    rst_p[0] = 1'b0;
    repeat (9) tick();
    rst_p[0] = 1'b1;
    tick();
    chk("rstrt_at9_tp0", timeout_p[0], 0);
    rst_p[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("rstrt_after_tp0", timeout_p[0], (k == 10) ? 1 : 0);
    end

    // cascade 4/6/8
    do_reset();
    period[0] = 4; period[1] = 6; period[2] = 8;
    cascade_en = 1'b1;
    repeat (3) tick();
    en[0] = 1'b1;
    tick();
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk("casc_tp", timeout_p, (k == 4) ? 3'b001 : (k == 11) ? 3'b010 : (k == 20) ? 3'b100 : 3'b000);
      chk("casc_fatal", fatal_timeout, (k >= 20) ? 1 : 0);
    end
    svc = 3'b111;
    tick();
    svc = '0; en[0] = 1'b0;
    tick();
    chk("casc_svc_to", timeout, 0);
    chk("casc_fatal_sticky", fatal_timeout, 1);

    // cascade: service channel 0 while channel 1 is at count 3
    do_reset();
    period[0] = 4; period[1] = 6; period[2] = 8;
    cascade_en = 1'b1;
    repeat (3) tick();
    en[0] = 1'b1;
    tick();
    repeat (8) tick();
    chk("cs_cnt1", dut.g_ch[1].cnt_q, 3);
    chk("cs_act1_before", active[1], 1);
    svc = 3'b001;
    tick();
    svc = '0; en[0] = 1'b0;
    chk("cs_act1_after", active[1], 0);
    chk("cs_to0", timeout[0], 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("cs_tp_down", timeout_p[2:1], 0);
      chk("cs_fatal", fatal_timeout, 0);
    end

    // wide period with carry across dword boundary; period 0 channel stays idle
    do_reset();
    period[0] = 64'h1_0000_0010;
    en = 3'b011;
    tick();
    repeat (2) tick();
    force dut.g_ch[0].cnt_q = 64'h0000_0000_FFFF_FFF8;
    #2;
    release dut.g_ch[0].cnt_q;
    m_dl[0] = n + 64'h1_0000_0010 - 64'h0000_0000_FFFF_FFF8;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 8) chk("wide_carry", dut.g_ch[0].cnt_q, 64'h1_0000_0000);
      chk("wide_tp0", timeout_p[0], (k == 24) ? 1 : 0);
      chk("p0_act1", active[1], 0);
    end

    // async reset mid-count, then restart from 0 with enable held
    do_reset();
    period[0] = 10; period[1] = 3;
    en = 3'b011;
    tick();
    repeat (5) tick();
    chk("ar_cnt0", dut.g_ch[0].cnt_q, 5);
    chk("ar_to1", timeout[1], 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("ar_active", active, 0);
    chk("ar_timeout_p", timeout_p, 0);
    chk("ar_timeout", timeout, 0);
    chk("ar_fatal", fatal_timeout, 0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    chk("ar_cnt0_restart", dut.g_ch[0].cnt_q, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("ar_tp0", timeout_p[0], (k == 10) ? 1 : 0);
    end

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) period[i] = $urandom_range(0, 12);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) cascade_en = ~cascade_en;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
        rst_p[i] = ($urandom_range(0, 15) == 0);
        svc[i]   = ($urandom_range(0, 7) == 0);
        if (m_st[i] != 1 && $urandom_range(0, 9) == 0) period[i] = $urandom_range(0, 12);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
